// File: rtl/sm_ram_arb_pkg.sv
// Shared types and constants for the CPU/user data-RAM arbiter.
package sm_ram_arb_pkg;

  typedef enum logic {
    PRIO_CPU   = 1'b0,
    FORCE_USER = 1'b1
  } arb_mode_e;

  localparam logic ARB_CPU  = 1'b0;
  localparam logic ARB_USER = 1'b1;

  localparam int DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/sm_ram_arbiter_if.sv
// One requester port of the data-RAM arbiter: request/grant handshake plus read return.
interface sm_ram_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sm_ram_arb_rport.sv
// Per-port read return: captures RAM data on a granted read, pulses rvalid the next cycle.
module sm_ram_arb_rport (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic [31:0] ram_rdata,
  output logic        rvalid,
  output logic [31:0] rdata
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= capture;
      if (capture) rdata <= ram_rdata;
    end
  end

endmodule

// File: rtl/sm_ram_arbiter.sv
// Shares one single-port RAM between CPU and user ports, one access per cycle.
// Default: CPU priority with user aging; SM_RAM_ARB_RR_EN selects round-robin on conflict.
module sm_ram_arbiter
  import sm_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sm_ram_arbiter_if.slave       cpu,
  sm_ram_arbiter_if.slave       user,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  logic        cpu_gnt;
  logic        user_gnt;
  logic        cpu_rvalid;
  logic        user_rvalid;
  logic [31:0] cpu_rdata;
  logic [31:0] user_rdata;

`ifdef SM_RAM_ARB_RR_EN
  logic last_gnt;

  always_comb begin
    cpu_gnt  = cpu.req  && (!user.req || (last_gnt == ARB_USER));
    user_gnt = user.req && (!cpu.req  || (last_gnt == ARB_CPU));
  end

  // Reset to user so the CPU takes the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_gnt <= ARB_USER;
    else if (cpu_gnt)  last_gnt <= ARB_CPU;
    else if (user_gnt) last_gnt <= ARB_USER;
  end
`else
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  arb_mode_e  mode;

  always_comb begin
    cpu_gnt  = cpu.req  && !((mode == FORCE_USER) && user.req);
    user_gnt = user.req && ((mode == FORCE_USER) || !cpu.req);
    wait_nxt = '0;
    if (user.req && !user_gnt)
      wait_nxt = (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1;
  end

  // mode is registered alongside the counter so it tracks wait_cnt == MAX_WAIT exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      mode     <= PRIO_CPU;
    end else begin
      wait_cnt <= wait_nxt;
      mode     <= (wait_nxt == MAX_W) ? FORCE_USER : PRIO_CPU;
    end
  end
`endif

  always_comb begin
    ram_addr  = user_gnt ? user.addr[ADDR_WIDTH+1:2] : cpu.addr[ADDR_WIDTH+1:2];
    ram_wdata = user_gnt ? user.wdata : cpu.wdata;
    ram_we    = rst_n && ((cpu_gnt && cpu.we) || (user_gnt && user.we));
  end

  sm_ram_arb_rport u_cpu_rport (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (cpu_gnt && !cpu.we),
    .ram_rdata (ram_rdata),
    .rvalid    (cpu_rvalid),
    .rdata     (cpu_rdata)
  );

  sm_ram_arb_rport u_user_rport (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (user_gnt && !user.we),
    .ram_rdata (ram_rdata),
    .rvalid    (user_rvalid),
    .rdata     (user_rdata)
  );

  assign cpu.gnt     = cpu_gnt;
  assign cpu.rvalid  = cpu_rvalid;
  assign cpu.rdata   = cpu_rdata;
  assign user.gnt    = user_gnt;
  assign user.rvalid = user_rvalid;
  assign user.rdata  = user_rdata;

  // Byte-lane and out-of-range address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{cpu.addr[31:ADDR_WIDTH+2], cpu.addr[1:0],
                         user.addr[31:ADDR_WIDTH+2], user.addr[1:0]};

endmodule
